// File: rtl/md5_pkg.sv
// rtl/md5_pkg.sv - shared constants, state type and error bit indices for MD5 unpadding
// Purpose: common definitions used by md5_unpadding and md5_pad_check.
package md5_pkg;
  localparam int         MD5_BLOCK_BITS  = 512;
  localparam int         MD5_BLOCK_BYTES = 64;
  localparam int         MD5_LEN_BYTE    = 56;
  localparam logic [7:0] MD5_PAD_BYTE    = 8'h80;

  // out_err bit positions
  localparam int ERR_PAD = 0;
  localparam int ERR_LEN = 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HELD  = 2'd1,
    LAST2 = 2'd2
  } md5_state_e;
endpackage

// File: rtl/md5_pad_check.sv
// rtl/md5_pad_check.sv - combinational padding checker and byte masker for one 512-bit block
// Purpose: verifies the 0x80 marker and a zero-fill byte range, and zeroes bytes >= keep.
// Ports:
//   block_i      block under test, byte i = bits 8i..8i+7
//   keep_i       number of leading bytes passed through to data_o (0..64)
//   marker_en_i  check byte marker_pos_i for 0x80
//   marker_pos_i marker byte position
//   zero_start_i first byte that must be zero
//   zero_end_i   one past the last byte that must be zero
//   pad_ok_o     marker and zero range well formed
//   data_o       block with bytes >= keep_i forced to zero
module md5_pad_check
  import md5_pkg::*;
(
  input  logic [0:MD5_BLOCK_BITS-1] block_i,
  input  logic [6:0]                keep_i,
  input  logic                      marker_en_i,
  input  logic [5:0]                marker_pos_i,
  input  logic [6:0]                zero_start_i,
  input  logic [6:0]                zero_end_i,
  output logic                      pad_ok_o,
  output logic [0:MD5_BLOCK_BITS-1] data_o
);
  always_comb begin
    pad_ok_o = 1'b1;
    data_o   = '0;
    if (marker_en_i && (block_i[{marker_pos_i, 3'b000} +: 8] != MD5_PAD_BYTE)) begin
      pad_ok_o = 1'b0;
    end
    for (int i = 0; i < MD5_BLOCK_BYTES; i++) begin
      if ((7'(i) >= zero_start_i) && (7'(i) < zero_end_i) && (block_i[8*i +: 8] != 8'h00)) begin
        pad_ok_o = 1'b0;
      end
      if (7'(i) < keep_i) begin
        data_o[8*i +: 8] = block_i[8*i +: 8];
      end
    end
  end
endmodule

// File: rtl/md5_unpadding.sv
// rtl/md5_unpadding.sv - recovers message bytes from a stream of padded MD5 blocks
// Purpose: strips marker, zero fill and length field, flags malformed padding and
//          block-count mismatches. A one-block hold buffer absorbs padding that
//          spills into a final block carrying no message bytes.
// Ports:
//   clk, rst                     clock, async active-low reset
//   in_valid/in_ready/in_last    padded block handshake, in_data byte 0 first
//   out_valid/out_ready/out_last message block handshake
//   out_data/out_bytes           message bytes and their count (0..64)
//   out_err                      bit0 malformed padding, bit1 length/count mismatch
module md5_unpadding
  import md5_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      in_last,
  input  logic [0:MD5_BLOCK_BITS-1] in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [0:MD5_BLOCK_BITS-1] out_data,
  output logic [6:0]                out_bytes,
  output logic                      out_last,
  output logic [1:0]                out_err
);
  localparam logic [63:0] CNT_MASK = (64'd1 << CNT_W) - 64'd1;

  md5_state_e                state_q, state_d;
  logic [0:MD5_BLOCK_BITS-1] hold_q, hold_d;
  logic [6:0]                hold_bytes_q, hold_bytes_d;
  logic [1:0]                hold_err_q, hold_err_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d, cnt_inc;
  logic                      out_valid_q, out_valid_d;
  logic [0:MD5_BLOCK_BITS-1] out_data_q, out_data_d;
  logic [6:0]                out_bytes_q, out_bytes_d;
  logic                      out_last_q, out_last_d;
  logic [1:0]                out_err_q, out_err_d;

  logic [63:0]               len, n_bytes, blocks_exp;
  logic [5:0]                k;
  logic                      k_hi, misaligned, cnt_mismatch;
  logic                      in_ok, hold_ok, out_free, accept;
  logic [0:MD5_BLOCK_BITS-1] in_masked, hold_masked;
  logic [6:0]                in_keep, in_zero_start;
  logic [1:0]                err_in, err_hold, err_orphan;

  // Length field is little-endian: byte 56 carries L[7:0].
  always_comb begin
    len = '0;
    for (int i = 0; i < 8; i++) begin
      len[8*i +: 8] = in_data[8*(MD5_LEN_BYTE+i) +: 8];
    end
  end

  assign n_bytes      = len >> 3;
  assign k            = n_bytes[5:0];
  assign k_hi         = (k >= 6'd56);
  assign misaligned   = (len[2:0] != 3'b000);
  assign blocks_exp   = ((n_bytes + 64'd8) >> 6) + 64'd1;
  assign cnt_inc      = cnt_q + CNT_W'(1);
  // Count includes the last block itself; only the low CNT_W bits are compared.
  assign cnt_mismatch = (((blocks_exp ^ 64'(cnt_inc)) & CNT_MASK) != 64'd0);

  // When k >= 56 the input block is pure zero fill plus length: no marker, no bytes kept.
  assign in_keep       = k_hi ? 7'd0 : {1'b0, k};
  assign in_zero_start = k_hi ? 7'd0 : ({1'b0, k} + 7'd1);

  md5_pad_check u_in_check (
    .block_i      (in_data),
    .keep_i       (in_keep),
    .marker_en_i  (!k_hi),
    .marker_pos_i (k),
    .zero_start_i (in_zero_start),
    .zero_end_i   (7'(MD5_LEN_BYTE)),
    .pad_ok_o     (in_ok),
    .data_o       (in_masked)
  );

  md5_pad_check u_hold_check (
    .block_i      (hold_q),
    .keep_i       ({1'b0, k}),
    .marker_en_i  (1'b1),
    .marker_pos_i (k),
    .zero_start_i ({1'b0, k} + 7'd1),
    .zero_end_i   (7'(MD5_BLOCK_BYTES)),
    .pad_ok_o     (hold_ok),
    .data_o       (hold_masked)
  );

  always_comb begin
    err_in              = '0;
    err_in[ERR_PAD]     = misaligned | !in_ok;
    err_in[ERR_LEN]     = cnt_mismatch;
    err_hold            = '0;
    err_hold[ERR_PAD]   = misaligned | !in_ok | !hold_ok;
    err_hold[ERR_LEN]   = cnt_mismatch;
    err_orphan          = '0;
    err_orphan[ERR_PAD] = misaligned | !in_ok;
    err_orphan[ERR_LEN] = 1'b1;
  end

  assign out_free = !out_valid_q || out_ready;
  assign in_ready = ((state_q == EMPTY) || (state_q == HELD)) && out_free;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_bytes_d = hold_bytes_q;
    hold_err_d   = hold_err_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_bytes_d  = out_bytes_q;
    out_last_d   = out_last_q;
    out_err_d    = out_err_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (state_q == LAST2) begin
      if (out_free) begin
        out_valid_d = 1'b1;
        out_data_d  = hold_q;
        out_bytes_d = hold_bytes_q;
        out_last_d  = 1'b1;
        out_err_d   = hold_err_q;
        state_d     = EMPTY;
      end
    end else if (accept) begin
      if (!in_last) begin
        cnt_d = cnt_inc;
        if (state_q == HELD) begin
          out_valid_d = 1'b1;
          out_data_d  = hold_q;
          out_bytes_d = 7'd64;
          out_last_d  = 1'b0;
          out_err_d   = '0;
        end
        hold_d  = in_data;
        state_d = HELD;
      end else begin
        cnt_d       = '0;
        state_d     = EMPTY;
        out_valid_d = 1'b1;
        out_last_d  = 1'b1;
        if (!k_hi && (state_q == HELD)) begin
          // Flush the held full block now; the trimmed final block follows from LAST2.
          out_data_d   = hold_q;
          out_bytes_d  = 7'd64;
          out_last_d   = 1'b0;
          out_err_d    = '0;
          hold_d       = in_masked;
          hold_bytes_d = {1'b0, k};
          hold_err_d   = err_in;
          state_d      = LAST2;
        end else if (!k_hi) begin
          out_data_d  = in_masked;
          out_bytes_d = {1'b0, k};
          out_err_d   = err_in;
        end else if (state_q == HELD) begin
          // Padding spilled: hold carries the message tail, the input block is discarded.
          out_data_d  = hold_masked;
          out_bytes_d = {1'b0, k};
          out_err_d   = err_hold;
        end else begin
          out_data_d  = in_masked;
          out_bytes_d = 7'd0;
          out_err_d   = err_orphan;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= EMPTY;
      hold_q       <= '0;
      hold_bytes_q <= '0;
      hold_err_q   <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_bytes_q  <= '0;
      out_last_q   <= 1'b0;
      out_err_q    <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_bytes_q <= hold_bytes_d;
      hold_err_q   <= hold_err_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_bytes_q  <= out_bytes_d;
      out_last_q   <= out_last_d;
      out_err_q    <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_bytes = out_bytes_q;
  assign out_last  = out_last_q;
  assign out_err   = out_err_q;
endmodule

// File: tb/tb_md5_unpadding.sv
// tb/tb_md5_unpadding.sv - self-checking bench for md5_unpadding with a message-level reference model
module tb_md5_unpadding;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic [0:511] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [0:511] out_data;
  logic [6:0]   out_bytes;
  logic         out_last;
  logic [1:0]   out_err;

  md5_unpadding #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_bytes(out_bytes), .out_last(out_last), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:511] data;
    logic [6:0]   bytes;
    logic         last;
    logic [1:0]   err;
  } beat_t;

  int           n_pass = 0;
  int           n_total = 0;
  byte unsigned msg_q[$];
  logic [0:511] blk_q[$];
  beat_t        exp_q[$];

  task automatic chk(string tag, logic [511:0] obs, logic [511:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Standard MD5 padding of msg_q into blk_q.
  task automatic pad_msg();
    byte unsigned    p[$];
    longint unsigned lbits;
    logic [0:511]    blk;
    p = msg_q;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    lbits = longint'(msg_q.size()) * 8;
    for (int i = 0; i < 8; i++) p.push_back(8'(lbits >> (8 * i)));
    blk_q.delete();
    for (int b = 0; b < p.size() / 64; b++) begin
      for (int j = 0; j < 64; j++) blk[8*j +: 8] = p[64*b + j];
      blk_q.push_back(blk);
    end
  endtask

  // Expected output: the message cut into 64-byte beats, the last beat holding the remainder.
  task automatic model_msg();
    beat_t b;
    int    n;
    n = msg_q.size();
    for (int c = 0; c <= n / 64; c++) begin
      b.data  = '0;
      b.bytes = 7'((c < n / 64) ? 64 : n % 64);
      b.last  = (c == n / 64);
      b.err   = 2'b00;
      for (int j = 0; j < int'(b.bytes); j++) b.data[8*j +: 8] = msg_q[64*c + j];
      exp_q.push_back(b);
    end
  endtask

  task automatic cmp_beat(string tag);
    beat_t e;
    e = exp_q.pop_front();
    chk({tag, "_data"}, out_data, e.data);
    chk({tag, "_bytes"}, out_bytes, e.bytes);
    chk({tag, "_last"}, out_last, e.last);
    chk({tag, "_err"}, out_err, e.err);
  endtask

  // Streams blk_q into the DUT and scores every output beat against exp_q.
  task automatic run_blocks(string tag, int stall_pct);
    int           idx;
    int           idle;
    logic         held;
    logic [0:511] held_data;
    idx = 0; idle = 0; held = 1'b0; held_data = '0;
    for (int cyc = 0; cyc < 3000 && idle < 4; cyc++) begin
      @(negedge clk);
      in_valid  = (idx < blk_q.size()) && ($urandom_range(99) >= stall_pct / 2);
      in_data   = (idx < blk_q.size()) ? blk_q[idx] : '0;
      in_last   = (idx == blk_q.size() - 1);
      out_ready = (idx >= blk_q.size() && exp_q.size() == 0) ? 1'b1 : ($urandom_range(99) >= stall_pct);
      #1;
      if (held) begin
        chk({tag, "_stall_valid"}, out_valid, 1'b1);
        chk({tag, "_stall_data"}, out_data, held_data);
      end
      if (out_valid && out_ready) begin
        chk({tag, "_beat_expected"}, exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) cmp_beat(tag);
      end
      held      = out_valid && !out_ready;
      held_data = out_data;
      if (in_valid && in_ready) idx++;
      idle = (idx >= blk_q.size() && exp_q.size() == 0) ? idle + 1 : 0;
    end
    chk({tag, "_all_sent"}, idx, blk_q.size());
    chk({tag, "_all_beats"}, exp_q.size(), 0);
    exp_q.delete();
    in_valid = 1'b0;
  endtask

  task automatic rand_blk(output logic [0:511] b);
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
  endtask

  task automatic abc_msg();
    msg_q.delete();
    msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
  endtask

  initial begin
    logic [0:511] tmp;
    beat_t        b;
    int           lens[10] = '{0, 1, 55, 56, 63, 64, 65, 119, 120, 128};

    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_bytes", out_bytes, 7'd0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_err", out_err, 2'b00);
    chk("rst_out_data", out_data, 512'd0);

    // "abc"
    abc_msg(); pad_msg(); model_msg();
    chk("abc_blocks", blk_q.size(), 1);
    run_blocks("abc", 0);

    // 60-byte message spilling padding into a second block
    msg_q.delete();
    for (int i = 0; i < 60; i++) msg_q.push_back(8'(8'h41 + i / 10));
    pad_msg(); model_msg();
    run_blocks("m60", 0);

    // Bad marker in "abc"
    abc_msg(); pad_msg();
    tmp = blk_q[0]; tmp[24 +: 8] = 8'h81; blk_q[0] = tmp;
    b.data = '0; b.data[0 +: 24] = 24'h616263; b.bytes = 7'd3; b.last = 1'b1; b.err = 2'b01;
    exp_q.push_back(b);
    run_blocks("badmark", 0);

    // Length not a multiple of 8
    abc_msg(); pad_msg();
    tmp = blk_q[0]; tmp[8*56 +: 8] = 8'h19; blk_q[0] = tmp;
    b.err = 2'b01;
    exp_q.push_back(b);
    run_blocks("misalign", 0);

    // Orphan final block with L=0x1e0
    blk_q.delete();
    tmp = '0; tmp[8*56 +: 8] = 8'he0; tmp[8*57 +: 8] = 8'h01; blk_q.push_back(tmp);
    b.data = '0; b.bytes = 7'd0; b.last = 1'b1; b.err = 2'b10;
    exp_q.push_back(b);
    run_blocks("orphan", 0);

    // Extra block ahead of "abc": block count mismatch
    abc_msg(); pad_msg();
    rand_blk(tmp);
    blk_q.push_front(tmp);
    b.data = tmp; b.bytes = 7'd64; b.last = 1'b0; b.err = 2'b00;
    exp_q.push_back(b);
    b.data = '0; b.data[0 +: 24] = 24'h616263; b.bytes = 7'd3; b.last = 1'b1; b.err = 2'b10;
    exp_q.push_back(b);
    run_blocks("cntmis", 0);

    // 64-byte message with a 5-cycle output stall while in LAST2
    msg_q.delete();
    for (int i = 0; i < 64; i++) msg_q.push_back(8'($urandom));
    pad_msg(); model_msg();
    @(negedge clk);
    in_valid = 1'b1; in_data = blk_q[0]; in_last = 1'b0; out_ready = 1'b0;
    #1 chk("m64_ready0", in_ready, 1'b1);
    @(negedge clk);
    in_data = blk_q[1]; in_last = 1'b1;
    #1 chk("m64_ready1", in_ready, 1'b1);
    @(negedge clk);
    rand_blk(tmp);
    in_data = tmp; in_last = 1'b0;
    #1 chk("m64_valid0", out_valid, 1'b1);
    tmp = out_data;
    chk("m64_beat0_data", out_data, exp_q[0].data);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      #1;
      chk("m64_stall_valid", out_valid, 1'b1);
      chk("m64_stall_data", out_data, tmp);
      chk("m64_stall_ready", in_ready, 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1 chk("m64_last2_ready", in_ready, 1'b0);
    chk("m64_drain_valid", out_valid, 1'b1);
    cmp_beat("m64_b0");
    @(negedge clk);
    #1 chk("m64_valid1", out_valid, 1'b1);
    chk("m64_empty_ready", in_ready, 1'b1);
    cmp_beat("m64_b1");
    @(negedge clk);
    #1 chk("m64_idle", out_valid, 1'b0);

    // Boundary lengths, then random lengths, with random back-pressure
    for (int t = 0; t < 18; t++) begin
      msg_q.delete();
      for (int i = 0; i < ((t < 10) ? lens[t] : int'($urandom_range(200))); i++)
        msg_q.push_back(8'($urandom));
      pad_msg(); model_msg();
      run_blocks($sformatf("rnd%0d", t), (t < 10) ? 30 : int'($urandom_range(60)));
    end

    // Reset while HELD with a beat pending
    @(negedge clk);
    rand_blk(tmp);
    in_valid = 1'b1; in_data = tmp; in_last = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rand_blk(tmp);
    in_data = tmp;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("mid_valid_before", out_valid, 1'b1);
    #1 rst = 1'b0;
    #1 chk("mid_valid_async", out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("mid_ready_after", in_ready, 1'b1);
    abc_msg(); pad_msg(); model_msg();
    run_blocks("after_rst", 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/md5_unpadding.md
Name: md5_unpadding

Overview:
- Inverse of the MD5 padding stage: consumes a stream of 512-bit padded MD5 blocks and recovers the original message bytes.
- Strips the 0x80 marker, the zero fill and the 64-bit length field, and checks that the padding is well formed.
- Used for loopback verification of the padder and for self-check paths in front of the compression core.
- Keeps a one-block holding buffer, because padding can spill into a final block that carries no message bytes.

Parameters:
- CNT_W, 32, width of the accepted-block counter used for the block-count check.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- in_valid  input  1  padded block presented.
- in_last  input  1  block is the final padded block of the message.
- in_data  input  [0:511]  padded block; byte i = bits 8i..8i+7, byte 0 first.
- in_ready  output  1  block accepted when in_valid && in_ready.
- out_valid  output  1  message block presented.
- out_ready  input  1  sink accepts when out_valid && out_ready.
- out_data  output  [0:511]  message bytes; bytes >= out_bytes forced to zero.
- out_bytes  output  7  valid message bytes in out_data, 0..64.
- out_last  output  1  final message block.
- out_err  output  2  valid with out_last. bit0 = malformed padding; bit1 = length/block-count mismatch.

Behaviour:
- Reset (rst low, async): state EMPTY; out_valid, out_last, out_bytes, out_err, out_data, block counter and hold register all clear. in_ready is 1 after reset release.
- Output register: out_* hold stable while out_valid && !out_ready.
- in_ready is 1 only when the state is EMPTY or HELD and the output register is free or being drained this cycle.
- Length field: L = little-endian 64-bit value in bytes 56..63 (byte 56 = L[7:0]).
  - N = L>>3.
  - k = N mod 64.
  - Expected block count T = ((N+8)>>6)+1.
  - Compare only the low CNT_W bits of T.
- States:
  - EMPTY: no hold.
  - HELD: hold occupied.
  - LAST2: two final beats pending.
- Non-last block accepted:
  - In EMPTY: store it in hold, go to HELD.
  - In HELD: emit hold as a full block (out_bytes=64, out_last=0), store the new block, stay HELD.
  - Counter increments on every accepted block, including the last.
- Last block B, case k <= 55:
  - Check: B[k]=0x80 and bytes k+1..55 are zero; otherwise set err bit0.
  - From EMPTY: emit B trimmed to k bytes, out_last=1, go to EMPTY.
  - From HELD: emit hold as full (out_last=0), load the trimmed B into hold, go to LAST2. LAST2 then emits hold with out_last=1 and goes to EMPTY. in_ready stays 0 in LAST2.
- Last block B, case k >= 56:
  - Requires hold; the padding lives in hold.
  - Check: hold[k]=0x80 and hold bytes k+1..63 zero, and B bytes 0..55 zero; otherwise set err bit0.
  - Emit hold trimmed to k bytes, out_last=1. B is discarded. Go to EMPTY.
  - From EMPTY, set err bit1 and emit B with out_bytes=0, out_last=1.
- Count check: accepted-block count != T sets err bit1.
- Counter: clears after each last block is accepted.
- L not a multiple of 8: set err bit0 and treat k as floor.
- N=0: single block with 0x80 at byte 0 → one beat, out_bytes=0, out_last=1.
- Latency: output registered one cycle after acceptance. A message of M blocks yields its final beat no earlier than one cycle after the last input handshake.
- Reset mid-message: all state, hold and counter are discarded immediately, and no partial output remains valid.

Decomposition:
- Shared package md5_pkg:
  - MD5_BLOCK_BITS=512.
  - MD5_LEN_BYTE=56.
  - MD5_PAD_BYTE=8'h80.
  - State enum {EMPTY, HELD, LAST2}.
  - err bit indices.
- One natural sub-module md5_pad_check. It is combinational and takes block, k, zero-range start/end and marker position. It returns a padding-ok flag and the byte-masked data. It is instantiated twice, for the hold path and the input path.

Test Plan:
- "abc" at bytes 0..2, 0x80 at byte 3, L=0x18, in_last=1 → one beat: out_bytes=3, out_data starts 616263 then zeros, out_last=1, out_err=0.
- 60-byte "AAAAAAAAAA...FFFFFFFFFF" over two blocks:
  - Block 1 = 60 message bytes, 0x80, zeros.
  - Block 2 = zeros, L=0x1e0.
  - Response: one beat, out_bytes=60, out_last=1, out_err=0. Block 2 produces no beat.
- 64-byte message, then block of 0x80, zeros, L=0x200 → beat 1: out_bytes=64, out_last=0. Beat 2: out_bytes=0, out_last=1, out_err=0.
- "abc" block with byte 3 = 0x81 → out_err=2'b01. Single last block with L=0x1e0 → out_err=2'b10, out_bytes=0.
- Hold out_ready=0 for 5 cycles during the 64-byte case → out_data stable, in_ready=0 in LAST2, no beat lost or duplicated.
- Assert rst low while in HELD → out_valid=0 asynchronously. A following "abc" message decodes cleanly with no count error.
